// File: rtl/comma_aligner.sv
// comma_aligner
// Serial-to-parallel front end of the 8b/10b receive path. Bits are shifted
// in on CRCLK, and the shift window is searched for the K28.5 comma in either
// running disparity. Symbol framing locks after ACQ_COMMAS aligned commas.
// After that, framed 10-bit symbols are presented with a one-cycle strobe
// every 10 CRCLK. Framing is dropped after LOSS_COMMAS consecutive
// misaligned commas.
//
// Parameters:
//   ACQ_COMMAS   aligned commas needed to declare lock (1..7)
//   LOSS_COMMAS  consecutive misaligned commas that force loss of lock (1..7)
// Ports:
//   CRCLK         recovered bit clock (rising edge)
//   Reset         asynchronous, active-high reset
//   serial_in     one received bit per CRCLK
//   data_out      framed symbol; bit 9 is the first-received bit
//   symbol_valid  one-cycle strobe when data_out holds a new framed symbol
//   locked        high while framing is acquired
//   comma_det     one-cycle pulse when a K28.5 sits in the window at any phase
module comma_aligner #(
    parameter int ACQ_COMMAS  = 3,
    parameter int LOSS_COMMAS = 2
) (
    input  logic       CRCLK,
    input  logic       Reset,
    input  logic       serial_in,
    output logic [9:0] data_out,
    output logic       symbol_valid,
    output logic       locked,
    output logic       comma_det
);

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;
    localparam logic [2:0] ACQ_N     = 3'(ACQ_COMMAS);
    localparam logic [2:0] LOSS_N    = 3'(LOSS_COMMAS);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [9:0] sr;
    logic [3:0] p, p_nxt;
    logic [2:0] acq, acq_nxt, acq_inc;
    logic [2:0] miss, miss_nxt, miss_inc;
    logic       comma_hit;
    logic       boundary;
    logic       load_data;
    logic       sv_nxt;

    assign comma_hit = (sr == K28_5_RDN) || (sr == K28_5_RDP);
    assign boundary  = (p == 4'd0);

    // Both counters saturate at 7 rather than wrapping.
    assign acq_inc  = (acq  == 3'd7) ? acq  : acq  + 3'd1;
    assign miss_inc = (miss == 3'd7) ? miss : miss + 3'd1;

    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves a value unassigned and infers a latch.
        state_nxt = state;
        p_nxt     = (p == 4'd9) ? 4'd0 : p + 4'd1;
        acq_nxt   = acq;
        miss_nxt  = miss;
        load_data = 1'b0;
        sv_nxt    = 1'b0;

        unique case (state)
            HUNT: begin
                // Any comma defines the framing: this cycle becomes a boundary.
                if (comma_hit) begin
                    p_nxt     = 4'd1;
                    acq_nxt   = 3'd1;
                    load_data = 1'b1;
                    if (ACQ_N == 3'd1) begin
                        state_nxt = LOCKED;
                        sv_nxt    = 1'b1;
                    end else begin
                        state_nxt = SYNC;
                    end
                end
            end

            SYNC: begin
                if (boundary) begin
                    load_data = 1'b1;
                    if (comma_hit) begin
                        acq_nxt = acq_inc;
                        if (acq_inc >= ACQ_N) begin
                            state_nxt = LOCKED;
                            sv_nxt    = 1'b1;
                        end
                    end
                end else if (comma_hit) begin
                    // Comma at a different phase: restart acquisition there.
                    p_nxt     = 4'd1;
                    acq_nxt   = 3'd1;
                    load_data = 1'b1;
                end
            end

            LOCKED: begin
                if (boundary) begin
                    load_data = 1'b1;
                    sv_nxt    = 1'b1;
                    if (comma_hit) begin
                        miss_nxt = 3'd0;
                    end
                end else if (comma_hit) begin
                    miss_nxt = miss_inc;
                    if (miss_inc >= LOSS_N) begin
                        state_nxt = HUNT;
                        miss_nxt  = 3'd0;
                        acq_nxt   = 3'd0;
                    end
                end
            end

            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge CRCLK or posedge Reset) begin
        if (Reset) begin
            state        <= HUNT;
            sr           <= '0;
            p            <= '0;
            acq          <= '0;
            miss         <= '0;
            data_out     <= '0;
            symbol_valid <= 1'b0;
            locked       <= 1'b0;
            comma_det    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values of the others, including sr feeding comma_hit.
            state        <= state_nxt;
            sr           <= {sr[8:0], serial_in};
            p            <= p_nxt;
            acq          <= acq_nxt;
            miss         <= miss_nxt;
            symbol_valid <= sv_nxt;
            locked       <= (state_nxt == LOCKED);
            comma_det    <= comma_hit;
            if (load_data) begin
                data_out <= sr;
            end
        end
    end

endmodule

// File: doc/comma_aligner.md
# comma_aligner

Serial-to-parallel front end of the 8b/10b receive path. Shifts the recovered serial bit stream in on CRCLK and searches it for the K28.5 comma in either running disparity. It locks symbol framing once enough aligned commas have been seen, then presents framed 10-bit symbols with a one-cycle strobe every 10 CRCLK. It feeds the downstream comma/symbol-clock stage and the 10b/8b decoder.

## Interface
- ACQ_COMMAS, 3: aligned commas required to declare lock (range 1..7).
- LOSS_COMMAS, 2: consecutive misaligned commas while locked that force loss of lock (range 1..7).
- CRCLK, input, 1: recovered bit clock; all state changes on its rising edge.
- Reset, input, 1: reset, asynchronous, active-high.
- serial_in, input, 1: one received bit per CRCLK.
- data_out, output, 10: framed symbol. Bit 9 is the first-received bit, bit 0 the last.
- symbol_valid, output, 1: one-cycle strobe; data_out holds a new framed symbol.
- locked, output, 1: framing acquired.
- comma_det, output, 1: one-cycle pulse when a K28.5 sits in the shift window at any phase.

## Operation
- Shift register sr[9:0]: sr <= {sr[8:0], serial_in} every cycle, including during hunt.
- comma_hit (combinational from sr): high when sr == 10'b0011111010 (RD-) or sr == 10'b1100000101 (RD+). No other pattern matches.
- Phase counter p, 0..9, increments mod 10 every cycle. A cycle is a boundary when p == 0.
- Acquire counter acq and miss counter miss, 3 bits each, both saturating.
- FSM states:
  - HUNT:
    - comma_hit: treat this cycle as a boundary; p <= 1; acq <= 1; data_out <= sr; go to SYNC. If ACQ_COMMAS == 1, go directly to LOCKED instead.
  - SYNC:
    - Boundary with comma_hit: acq++, data_out <= sr. When acq reaches ACQ_COMMAS, go to LOCKED and pulse symbol_valid.
    - Boundary without comma: data_out <= sr; acq unchanged.
    - Non-boundary comma_hit: realign. p <= 1; acq <= 1; data_out <= sr; stay in SYNC.
  - LOCKED:
    - Every boundary: data_out <= sr; symbol_valid pulses.
    - Boundary comma_hit: miss <= 0.
    - Non-boundary comma_hit: miss++. On reaching LOSS_COMMAS: go to HUNT, locked <= 0, miss <= 0, acq <= 0. No symbol_valid on that cycle.
- locked is high exactly while the state is LOCKED (registered).
- symbol_valid is never asserted in HUNT or SYNC, except on the boundary that declares lock.
- comma_det <= comma_hit in every state.
- Reset, at any time including mid-symbol:
  - sr, p, acq, miss, data_out cleared to 0.
  - symbol_valid = 0, locked = 0, comma_det = 0.
  - State = HUNT.
  - Takes effect immediately, without waiting for a clock edge.

## Timing
- All outputs are registered; there is no combinational path from serial_in to any output.
- Latency: the last bit of a symbol is sampled at edge k (it enters sr[0]). That symbol appears on data_out, and symbol_valid and comma_det assert, after edge k+1.
- In LOCKED, symbol_valid pulses are exactly 10 CRCLK apart and each lasts 1 cycle.
- Lock latency: locked rises after edge k+1, where edge k shifts in the last bit of the ACQ_COMMAS-th aligned comma.
- Loss latency: locked falls after the edge following the LOSS_COMMAS-th misaligned comma's last bit.
- Reset deassertion: the first bit is sampled on the first rising CRCLK edge after Reset falls.
- Simultaneous events: Reset dominates everything. Boundary and non-boundary conditions are mutually exclusive by construction.

## Test plan
- Reset mid-stream:
  - Stimulus: drive random bits for 23 cycles, then pulse Reset between clock edges.
  - Response: data_out=0, symbol_valid=0, locked=0, comma_det=0 immediately; no symbol_valid until after a new acquisition.
- Acquisition RD-:
  - Stimulus: 7 filler bits 1010101, then 3× 0011111010, then repeated 1010101010.
  - Response: comma_det pulses 3 times, 10 cycles apart. locked and the first symbol_valid rise one edge after the third comma completes. Subsequent strobes every 10 cycles carry data_out=10'h2AA.
- Alternating disparity:
  - Stimulus: 0011111010, 1100000101, 0011111010.
  - Response: lock declared exactly as in the previous scenario. data_out shows 10'h0FA, 10'h305, 10'h0FA on successive boundaries.
- Bit slip while locked:
  - Stimulus: after lock, drop one serial bit, then send commas every 10 bits.
  - Response: first misaligned comma leaves locked=1 (miss=1). Second misaligned comma drops locked with no symbol_valid on that cycle. Three further commas re-lock at the new phase.
- Realign during SYNC:
  - Stimulus: 2 aligned commas, then 3 filler bits, then 3 commas.
  - Response: the acquire count restarts at the shifted phase. locked rises only after the third comma of the new group; no symbol_valid before then.
- Parameter corner:
  - Setup: ACQ_COMMAS=1, LOSS_COMMAS=1.
  - Response: a single comma locks immediately. A single misaligned comma drops lock immediately.
